// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address,
// IF/ID pipeline register, ID-stage redirect handling and a saturating
// fetch-stall counter for performance debug.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        BranchTaken,
  input  logic        Jump,
  input  logic [31:0] InstData,
  output logic [31:0] InstAddr,
  output logic [31:0] IFIDInstr,
  output logic [31:0] IFIDPCPlus4,
  output logic        IFIDValid,
  output logic [31:0] StallCount
);

  // Source of the next PC value.
  typedef enum logic [1:0] {
    PC_HOLD,
    PC_SEQ,
    PC_BRANCH,
    PC_JUMP
  } pc_sel_t;

  // PC and IF/ID PC+4 are always word aligned, so only bits [31:2] are stored.
  logic [29:0] pc_word;
  logic [29:0] pc_word_next;
  logic [29:0] pc_plus4_word;
  logic [31:0] ifid_instr;
  logic [29:0] ifid_pcp4_word;
  logic        ifid_valid;
  logic [31:0] stall_cnt;

  logic [29:0] branch_offset_word;
  logic [29:0] branch_target_word;
  logic [29:0] jump_target_word;
  pc_sel_t     pc_sel;
  logic        redirect;
  logic        stall_inc;

  assign pc_plus4_word = pc_word + 30'd1;

  // Targets are word addresses; the <<2 of the offset is implicit.
  assign branch_offset_word = {{14{ifid_instr[15]}}, ifid_instr[15:0]};
  assign branch_target_word = ifid_pcp4_word + branch_offset_word;
  assign jump_target_word   = {ifid_pcp4_word[29:26], ifid_instr[25:0]};

  // Select next-PC source: a valid-qualified redirect beats any stall, jump beats branch.
  always_comb begin
    pc_sel = PC_HOLD;
    if (ifid_valid && Jump) begin
      pc_sel = PC_JUMP;
    end else if (ifid_valid && BranchTaken) begin
      pc_sel = PC_BRANCH;
    end else if (PCWrite) begin
      pc_sel = PC_SEQ;
    end
  end

  assign redirect  = (pc_sel == PC_JUMP) || (pc_sel == PC_BRANCH);
  assign stall_inc = !PCWrite && !redirect;

  // Next-PC multiplexer.
  always_comb begin
    pc_word_next = pc_word;
    case (pc_sel)
      PC_SEQ:    pc_word_next = pc_plus4_word;
      PC_BRANCH: pc_word_next = branch_target_word;
      PC_JUMP:   pc_word_next = jump_target_word;
      default:   pc_word_next = pc_word;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_word <= RESET_PC[31:2];
    end else begin
      pc_word <= pc_word_next;
    end
  end

  // IF/ID pipeline register: bubble on redirect, otherwise load when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr     <= '0;
      ifid_pcp4_word <= '0;
      ifid_valid     <= 1'b0;
    end else if (redirect) begin
      ifid_instr     <= '0;
      ifid_pcp4_word <= '0;
      ifid_valid     <= 1'b0;
    end else if (IFIDWrite) begin
      ifid_instr     <= InstData;
      ifid_pcp4_word <= pc_plus4_word;
      ifid_valid     <= 1'b1;
    end
  end

  // Saturating count of fetch-stall edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign InstAddr    = {pc_word, 2'b00};
  assign IFIDInstr   = ifid_instr;
  assign IFIDPCPlus4 = {ifid_pcp4_word, 2'b00};
  assign IFIDValid   = ifid_valid;
  assign StallCount  = stall_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table, hand sequences for
// multi-cycle corners, and randomized traffic against a behavioural model.
module tb_if_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        pcw = 1'b0, ifw = 1'b0, br = 1'b0, jmp = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] addr, instr, pcp4, stall;
  logic        valid;

  // Auxiliary DUTs for high-address corners
  logic        a_pcw = 1'b0, a_ifw = 1'b0, a_br = 1'b0, a_jmp = 1'b0;
  logic [31:0] a_data = '0;
  logic [31:0] h_addr, h_instr, h_pcp4, h_stall;
  logic        h_valid;
  logic [31:0] w_addr, w_instr, w_pcp4, w_stall;
  logic        w_valid;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PCWrite(pcw), .IFIDWrite(ifw),
    .BranchTaken(br), .Jump(jmp), .InstData(data),
    .InstAddr(addr), .IFIDInstr(instr), .IFIDPCPlus4(pcp4),
    .IFIDValid(valid), .StallCount(stall)
  );

  if_stage #(.RESET_PC(32'h9000_0000)) u_hi (
    .clk(clk), .reset(reset), .PCWrite(a_pcw), .IFIDWrite(a_ifw),
    .BranchTaken(a_br), .Jump(a_jmp), .InstData(a_data),
    .InstAddr(h_addr), .IFIDInstr(h_instr), .IFIDPCPlus4(h_pcp4),
    .IFIDValid(h_valid), .StallCount(h_stall)
  );

  // Misaligned RESET_PC: low two bits must be dropped.
  if_stage #(.RESET_PC(32'hFFFF_FFFB)) u_wrap (
    .clk(clk), .reset(reset), .PCWrite(a_pcw), .IFIDWrite(a_ifw),
    .BranchTaken(1'b0), .Jump(1'b0), .InstData(a_data),
    .InstAddr(w_addr), .IFIDInstr(w_instr), .IFIDPCPlus4(w_pcp4),
    .IFIDValid(w_valid), .StallCount(w_stall)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [31:0] e_addr, input logic [31:0] e_instr,
                            input logic [31:0] e_pcp4, input logic e_valid, input logic [31:0] e_stall);
    check({tag, ".addr"},  addr,  e_addr);
    check({tag, ".instr"}, instr, e_instr);
    check({tag, ".pcp4"},  pcp4,  e_pcp4);
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    check({tag, ".stall"}, stall, e_stall);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural reference model state
  logic [31:0] m_pc, m_instr, m_pcp4, m_stall;
  logic        m_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = '0; m_pcp4 = '0; m_valid = 1'b0; m_stall = '0;
  endtask

  task automatic model_edge();
    logic signed [31:0] off;
    if (m_valid && (jmp || br)) begin
      if (jmp) begin
        m_pc = {m_pcp4[31:28], m_instr[25:0], 2'b00};
      end else begin
        off  = $signed(m_instr[15:0]);
        m_pc = m_pcp4 + off * 4;
      end
      m_instr = '0; m_pcp4 = '0; m_valid = 1'b0;
    end else begin
      if (ifw) begin
        m_instr = data; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      if (pcw) m_pc = m_pc + 32'd4;
      else if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    end
  endtask

  typedef struct {
    logic        pcw, ifw, br, jmp;
    logic [31:0] data;
    logic [31:0] e_addr, e_instr, e_pcp4;
    logic        e_valid;
    logic [31:0] e_stall;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Sequential fetch, load-use stall, branch (with stall), ignored branch on bubble,
    // PCWrite-only discard, IFIDWrite-only reload.
    tbl[0]  = '{1, 1, 0, 0, 32'hA000_0000, 32'h04, 32'hA000_0000, 32'h04, 1, 0};
    tbl[1]  = '{1, 1, 0, 0, 32'hA000_0001, 32'h08, 32'hA000_0001, 32'h08, 1, 0};
    tbl[2]  = '{1, 1, 0, 0, 32'hA000_0002, 32'h0C, 32'hA000_0002, 32'h0C, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 32'hA000_0003, 32'h10, 32'hA000_0003, 32'h10, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 32'hA000_0004, 32'h10, 32'hA000_0003, 32'h10, 1, 1};
    tbl[5]  = '{0, 0, 0, 0, 32'hA000_0004, 32'h10, 32'hA000_0003, 32'h10, 1, 2};
    tbl[6]  = '{1, 1, 0, 0, 32'hA000_0004, 32'h14, 32'hA000_0004, 32'h14, 1, 2};
    tbl[7]  = '{1, 1, 0, 0, 32'hA000_0005, 32'h18, 32'hA000_0005, 32'h18, 1, 2};
    tbl[8]  = '{1, 1, 0, 0, 32'hA000_0006, 32'h1C, 32'hA000_0006, 32'h1C, 1, 2};
    tbl[9]  = '{1, 1, 0, 0, 32'h1000_FFFC, 32'h20, 32'h1000_FFFC, 32'h20, 1, 2};
    tbl[10] = '{0, 0, 1, 0, 32'hA000_0007, 32'h10, 32'h0000_0000, 32'h00, 0, 2};
    tbl[11] = '{1, 1, 1, 0, 32'hA000_0008, 32'h14, 32'hA000_0008, 32'h14, 1, 2};
    tbl[12] = '{1, 0, 0, 0, 32'hA000_0009, 32'h18, 32'hA000_0008, 32'h14, 1, 2};
    tbl[13] = '{0, 1, 0, 0, 32'hA000_000A, 32'h18, 32'hA000_000A, 32'h1C, 1, 3};
    tbl[14] = '{1, 1, 0, 0, 32'hA000_000B, 32'h1C, 32'hA000_000B, 32'h1C, 1, 3};

    // ---- High-address corners: jump priority and PC wrap ----
    do_reset();
    check("hi.reset.addr", h_addr, 32'h9000_0000);
    check("wrap.reset.addr", w_addr, 32'hFFFF_FFF8);
    a_pcw = 1; a_ifw = 1; a_data = 32'h0800_0100;
    tick();
    check("hi.fetch.pcp4", h_pcp4, 32'h9000_0004);
    check("hi.fetch.instr", h_instr, 32'h0800_0100);
    check("wrap.fetch.addr", w_addr, 32'hFFFF_FFFC);
    a_br = 1; a_jmp = 1;
    tick();
    check("hi.jump.addr", h_addr, 32'h9000_0400);
    check("hi.jump.valid", {31'd0, h_valid}, 32'd0);
    check("hi.jump.pcp4", h_pcp4, 32'h0);
    check("wrap.addr", w_addr, 32'h0000_0000);
    check("wrap.pcp4", w_pcp4, 32'h0000_0000);
    check("wrap.valid", {31'd0, w_valid}, 32'd1);
    a_pcw = 0; a_ifw = 0; a_br = 0; a_jmp = 0;

    // ---- Directed table on the main DUT ----
    do_reset();
    check_main("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      pcw = tbl[i].pcw; ifw = tbl[i].ifw; br = tbl[i].br; jmp = tbl[i].jmp; data = tbl[i].data;
      tick();
      check_main($sformatf("tbl%0d", i), tbl[i].e_addr, tbl[i].e_instr, tbl[i].e_pcp4,
                 tbl[i].e_valid, tbl[i].e_stall);
    end

    // ---- Asynchronous reset mid-stall ----
    pcw = 0; ifw = 0; br = 0; jmp = 0;
    tick();
    check_main("stall_pre", 32'h1C, 32'hA000_000B, 32'h1C, 1'b1, 32'd4);
    #3 reset = 1'b1;
    #1 check_main("areset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1 reset = 1'b0;

    // ---- Randomized traffic against the model ----
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      pcw  = ($urandom_range(0, 3) != 0);
      ifw  = ($urandom_range(0, 3) != 0);
      br   = ($urandom_range(0, 7) == 0);
      jmp  = ($urandom_range(0, 15) == 0);
      data = $urandom;
      model_edge();
      tick();
      check_main("rnd", m_pc, m_instr, m_pcp4, m_valid, m_stall);
      if ($urandom_range(0, 63) == 0) begin
        #3 reset = 1'b1;
        #1 check_main("rnd_areset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b0;
        model_reset();
      end
    end

    // ---- Stall-counter saturation ----
    do_reset();
    model_reset();
    pcw = 0; ifw = 0; br = 0; jmp = 0; data = 32'h0;
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt;
    m_stall = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) begin
      model_edge();
      tick();
      check($sformatf("sat%0d", i), stall, m_stall);
    end
    check("sat.final", stall, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipelined MIPS core: holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline register. It sits directly upstream of the load-use hazard detector and consumes its `PCWrite` and `IFIDWrite` outputs to freeze fetch. It also takes the ID-stage branch/jump decision and redirects the PC, flushing the wrongly fetched instruction. A saturating stall counter is kept for performance debug.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset; must be word-aligned.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PCWrite`  in  1  from hazard detection; 0 freezes the PC.
- `IFIDWrite`  in  1  from hazard detection; 0 holds the IF/ID register.
- `BranchTaken`  in  1  ID-stage branch resolved taken (beq/bne compare true).
- `Jump`  in  1  ID-stage instruction is `j`.
- `InstData`  in  32  instruction word from instruction memory at `InstAddr`, valid in the same cycle (combinational read).
- `InstAddr`  out  32  current PC, drives instruction memory.
- `IFIDInstr`  out  32  registered instruction for ID.
- `IFIDPCPlus4`  out  32  registered PC+4 of that instruction.
- `IFIDValid`  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- `StallCount`  out  32  number of fetch-stall cycles since reset.

## Operation
- Reset, while `reset`=1: PC=`RESET_PC`, `IFIDInstr`=32'h0 (sll $0 NOP), `IFIDPCPlus4`=0, `IFIDValid`=0, `StallCount`=0.
- Targets, computed combinationally from the IF/ID register contents:
  - BranchTarget = `IFIDPCPlus4` + (sign-extended `IFIDInstr[15:0]` << 2), 32-bit modulo.
  - JumpTarget = {`IFIDPCPlus4[31:28]`, `IFIDInstr[25:0]`, 2'b00}.
- Per-edge update, highest priority first:
  1. Redirect (`Jump` or `BranchTaken`, qualified by `IFIDValid`=1):
     - PC <= JumpTarget if `Jump`, else BranchTarget. `Jump` wins if both are high.
     - IF/ID <= bubble (Instr 0, PCPlus4 0, Valid 0).
     - `PCWrite`/`IFIDWrite` are ignored; redirect overrides stall.
  2. No redirect:
     - If `PCWrite`=1: PC <= PC+4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
     - If `IFIDWrite`=1: `IFIDInstr` <= `InstData`, `IFIDPCPlus4` <= PC+4, `IFIDValid` <= 1.
     - `PCWrite`=1 with `IFIDWrite`=0 is legal: PC advances and IF/ID holds (the fetched word is discarded). `PCWrite`=0 with `IFIDWrite`=1 reloads the same PC's word.
- `BranchTaken`/`Jump` while `IFIDValid`=0 are ignored; this prevents a bubble's zero fields from redirecting.
- PC bits [1:0] are always 0: the register stores [31:2] only, and `RESET_PC[1:0]` is ignored.
- `StallCount` increments on each edge where `PCWrite`=0 and no redirect occurs. It saturates at 32'hFFFF_FFFF and never wraps.

## Timing
- `InstAddr` = PC register output, changing only on clock edges or reset.
- Fetch-to-ID latency: 1 cycle. The word at PC in cycle n appears on `IFIDInstr` after edge n+1.
- Redirect penalty: 1 bubble. Target is fetched in the cycle after the redirect edge, and `IFIDValid`=0 for exactly that cycle.
- Stall: PC and IF/ID hold for as many cycles as `PCWrite`/`IFIDWrite` are low. Fetch resumes on the first edge with them high; no instruction is lost or duplicated.
- Asynchronous reset mid-operation: all outputs go to reset values immediately, independent of `clk`. The first fetch after release is from `RESET_PC` on the first rising edge.

## Test plan
- Sequential fetch, no hazards, `RESET_PC`=0: after reset release, `InstAddr` steps 0,4,8,C on successive edges, and `IFIDPCPlus4` lags by one edge (4,8,C).
- Load-use stall: hold `PCWrite`=`IFIDWrite`=0 for 2 cycles at PC=0x10 → `InstAddr` stays 0x10 and IF/ID is unchanged for 2 cycles, `StallCount` goes 0→2, then fetch resumes at 0x14.
- Branch taken, `IFIDPCPlus4`=0x20, offset 16'hFFFC:
  - `BranchTaken`=1 for one edge → PC=0x10 and `IFIDValid`=0 for 1 cycle.
  - Same edge with `PCWrite`=0 → redirect still occurs and `StallCount` does not increment.
- Jump with `IFIDPCPlus4`=0x9000_0004, `IFIDInstr[25:0]`=26'h0000100, `Jump`=`BranchTaken`=1 → PC=0x9000_0400 (jump priority).
- Boundaries:
  - PC=0xFFFF_FFFC with `PCWrite`=1 → PC=0x0000_0000.
  - `BranchTaken`=1 while `IFIDValid`=0 → ignored, PC advances by 4.
  - `reset` asserted between edges mid-stall → outputs return to reset values without a clock edge.
- Saturation: preload `StallCount` near max (force) with `PCWrite`=0 → holds at 32'hFFFF_FFFF.
